// File: rtl/ysyx_23060096_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and small op-classification helpers.
package ysyx_23060096_mdu_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Divide/remainder ops all live in the upper half of funct3.
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // REM/REMU return the remainder half of the divider accumulator.
    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV)  || (op == MDU_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/ysyx_23060096_mdu_step.sv
// One radix-2 iteration of the MDU datapath, purely combinational.
// Multiply: accumulator is {partial_hi, multiplier_lo}; add the multiplicand
// into the high half when the current multiplier bit is set, then shift right.
// Divide (restoring): accumulator is {remainder, dividend/quotient}; shift
// left one bit, trial-subtract the divisor and shift the quotient bit in.
module ysyx_23060096_mdu_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      i_is_div,
    input  logic [2*DATA_WIDTH-1:0]   i_acc,
    input  logic [DATA_WIDTH-1:0]     i_opnd,
    output logic [2*DATA_WIDTH-1:0]   o_acc
);

    localparam int W = DATA_WIDTH;

    logic [W-1:0] w_hi;
    logic [W-1:0] w_lo;
    logic [W:0]   w_sum;
    logic [W:0]   w_shift_hi;
    logic         w_ge;
    logic [W-1:0] w_diff;

    assign w_hi = i_acc[2*W-1:W];
    assign w_lo = i_acc[W-1:0];

    // Evaluate both step flavours and select by operation class.
    always_comb begin
        w_sum      = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opnd} : {(W+1){1'b0}});
        w_shift_hi = {w_hi, w_lo[W-1]};
        // Remainder is always below the divisor, so the shifted value fits in
        // W+1 bits and a successful difference fits back into W bits.
        w_ge       = (w_shift_hi >= {1'b0, i_opnd});
        w_diff     = w_shift_hi[W-1:0] - i_opnd;
        o_acc      = {w_sum, w_lo[W-1:1]};
        if (i_is_div) begin
            if (w_ge) begin
                o_acc = {w_diff, w_lo[W-2:0], 1'b1};
            end else begin
                o_acc = {w_shift_hi[W-1:0], w_lo[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ysyx_23060096_mdu.sv
// Iterative RV32M multiply/divide unit with valid/ready on both sides.
// One operation in flight; DATA_WIDTH radix-2 steps per normal operation,
// divide-by-zero and signed overflow resolve in a single cycle.
// Optional build macro YSYX_23060096_MDU_TRACE_EN: simulation-only log line
// and accept-to-handshake cycle counter on every result handshake.
module ysyx_23060096_mdu
    import ysyx_23060096_mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [ADDR_WIDTH-1:0] out_rd
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [W-1:0]     W_MIN    = {1'b1, {(W-1){1'b0}}};

    mdu_state_e         r_state;
    mdu_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [2*W-1:0]     r_acc;
    logic [W-1:0]       r_opnd;
    logic               r_neg_main;
    logic               r_neg_rem;
    logic [W-1:0]       r_result;

    logic               w_accept;
    logic               w_calc_last;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [W-1:0]       w_a_mag;
    logic [W-1:0]       w_b_mag;
    logic               w_div0;
    logic               w_ovf;
    logic               w_special;
    logic [W-1:0]       w_special_res;
    logic [2*W-1:0]     w_step_acc;
    logic [2*W-1:0]     w_prod;
    logic [W-1:0]       w_quot;
    logic [W-1:0]       w_rem;
    logic [W-1:0]       w_final;

    assign in_ready    = (r_state == ST_IDLE) && rstn;
    assign out_valid   = (r_state == ST_DONE);
    assign out_result  = r_result;
    assign out_rd      = r_rd;
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_calc_last = (r_state == ST_CALC) && (r_cnt == CNT_LAST);
    assign w_is_div    = is_div(r_op);

    // Request decode: operand magnitudes, signs and the single-cycle cases.
    always_comb begin
        w_a_neg = is_signed_a(in_op) && in_a[W-1];
        w_b_neg = is_signed_b(in_op) && in_b[W-1];
        // The most negative value maps onto itself, which read unsigned is
        // exactly its magnitude, so no extra bit is needed.
        w_a_mag = w_a_neg ? -in_a : in_a;
        w_b_mag = w_b_neg ? -in_b : in_b;
        w_div0  = is_div(in_op) && (in_b == '0);
        w_ovf   = is_div(in_op) && is_signed_a(in_op) &&
                  (in_a == W_MIN) && (in_b == '1);
        w_special     = w_div0 || w_ovf;
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = is_rem(in_op) ? in_a : '1;
        end else if (w_ovf) begin
            w_special_res = is_rem(in_op) ? '0 : W_MIN;
        end
    end

    ysyx_23060096_mdu_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc)
    );

    // Sign correction of the final step's accumulator into the result.
    always_comb begin
        w_prod  = r_neg_main ? -w_step_acc : w_step_acc;
        w_quot  = r_neg_main ? -w_step_acc[W-1:0] : w_step_acc[W-1:0];
        // Remainder follows the dividend's sign only.
        w_rem   = r_neg_rem ? -w_step_acc[2*W-1:W] : w_step_acc[2*W-1:W];
        w_final = (r_op == MDU_MUL) ? w_prod[W-1:0] : w_prod[2*W-1:W];
        if (w_is_div) begin
            w_final = is_rem(r_op) ? w_rem : w_quot;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Iteration counter, restarted on every accept or abort.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (flush || w_accept) begin
            r_cnt <= '0;
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Working datapath: operands latched once at accept, then stepped.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op       <= in_op;
            r_opnd     <= is_div(in_op) ? w_b_mag : w_a_mag;
            r_acc      <= {{W{1'b0}}, (is_div(in_op) ? w_a_mag : w_b_mag)};
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
        end else if (r_state == ST_CALC) begin
            r_acc <= w_step_acc;
        end
    end

    // Result and destination index presented to writeback.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_result <= '0;
            r_rd     <= '0;
        end else if (w_accept) begin
            r_rd <= in_rd;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (w_calc_last && !flush) begin
            r_result <= w_final;
        end
    end

`ifdef YSYX_23060096_MDU_TRACE_EN
    int r_trace_cyc;

    // Simulation-only latency counter and handshake log.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_trace_cyc <= 0;
        end else begin
            r_trace_cyc <= r_trace_cyc + 1;
        end
        if (rstn && !flush && out_valid && out_ready) begin
            $display("mdu op=%d rd=%d res=0x%8x cycles=%d",
                     r_op, r_rd, r_result, r_trace_cyc + 1);
        end
    end
`else
`endif

endmodule

// File: tb/tb_ysyx_23060096_mdu.sv
// Self-checking bench for ysyx_23060096_mdu: directed cases with literal
// expectations, then randomized traffic against a cycle-level reference.
module tb_ysyx_23060096_mdu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    int n_vec = 0;
    int n_err = 0;

    ysyx_23060096_mdu #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result straight from the RV32M definitions.
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        int ia = a;
        int ib = b;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Ops that finish in the accept cycle: divide by zero, signed overflow.
    function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF;
    endfunction

    // Cycle-level model: busy/valid flags, edges remaining, result, rd.
    bit          m_busy = 0;
    bit          m_vld  = 0;
    int          m_left = 0;
    logic [31:0] m_res  = 0;
    logic [4:0]  m_rd   = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_busy = 0; m_vld = 0; m_res = 0; m_rd = 0;
        end else if (flush) begin
            m_busy = 0; m_vld = 0;
        end else if (m_vld) begin
            if (out_ready) begin m_vld = 0; m_busy = 0; end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) m_vld = 1;
        end else if (in_valid) begin
            m_busy = 1;
            m_res  = ref_mdu(in_op, in_a, in_b);
            m_rd   = in_rd;
            m_left = ref_fast(in_op, in_a, in_b) ? 0 : 32;
            if (m_left == 0) m_vld = 1;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("in_ready", in_ready, (!m_busy && rstn));
        check("out_valid", out_valid, m_vld);
        if (m_vld) begin
            check("out_result", out_result, m_res);
            check("out_rd", out_rd, m_rd);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_rd = 5'($urandom);
    endtask

    task automatic wait_valid(output int k, output bit found);
        k = 0; found = 0;
        while (k < 100 && !found) begin
            @(negedge clk);
            k++;
            if (out_valid) found = 1;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
        int k;
        bit found;
        out_ready = 1'b1;
        issue(op, a, b, rd);
        wait_valid(k, found);
        check({name, "_latency"}, k, exp_lat);
        check({name, "_result"}, found ? out_result : 32'hDEADDEAD, exp);
        check({name, "_rd"}, out_rd, rd);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return $urandom % 16;
            6: return -($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        bit found;
        logic [31:0] held_res;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
        in_a = 32'h0; in_b = 32'h0; in_rd = 5'd0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_rd", out_rd, 5'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Pin the model against hand-computed values
        check("model_mul", ref_mdu(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        check("model_mulh", ref_mdu(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
        check("model_mulhsu", ref_mdu(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
        check("model_div", ref_mdu(3'd4, 32'hFFFFFF9C, 32'd7), 32'hFFFFFFF2);
        check("model_rem", ref_mdu(3'd6, 32'hFFFFFF9C, 32'd7), 32'hFFFFFFFE);
        check("model_remu", ref_mdu(3'd7, 32'd100, 32'd7), 32'd2);

        // Directed operations
        run_op("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
        run_op("mulh",    3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33);
        run_op("mulhu",   3'd3, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33);
        run_op("mulhsu",  3'd2, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 33);
        run_op("divu",    3'd5, 32'd100,      32'd7,        5'd4,  32'd14,       33);
        run_op("remu",    3'd7, 32'd100,      32'd7,        5'd6,  32'd2,        33);
        run_op("div",     3'd4, 32'hFFFFFF9C, 32'd7,        5'd8,  32'hFFFFFFF2, 33);
        run_op("rem",     3'd6, 32'hFFFFFF9C, 32'd7,        5'd10, 32'hFFFFFFFE, 33);
        run_op("div0",    3'd4, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
        run_op("rem0",    3'd6, 32'd5,        32'd0,        5'd12, 32'd5,        1);
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h0,        1);

        // Backpressure in DONE
        out_ready = 1'b0;
        issue(3'd5, 32'd1000, 32'd3, 5'd9);
        wait_valid(k, found);
        check("bp_result", out_result, 32'd333);
        held_res = out_result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", out_valid, 1'b1);
            check("bp_result_held", out_result, held_res);
            check("bp_rd_held", out_rd, 5'd9);
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_last_valid", out_valid, 1'b1);
        @(negedge clk);
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Flush at count 10
        issue(3'd4, 32'h12345678, 32'h00001234, 5'd15);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("flush_no_valid", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Reset pulse in the middle of a second op
        issue(3'd3, 32'hDEADBEEF, 32'hCAFEF00D, 5'd16);
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rstmid_out_result", out_result, 32'h0);
        check("rstmid_out_rd", out_rd, 5'h0);
        check("rstmid_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("rstmid_no_valid", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        run_op("mul_after", 3'd0, 32'd3, 32'd4, 5'd7, 32'd12, 33);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_op     = 3'($urandom);
            in_a      = rnd_opnd();
            in_b      = rnd_opnd();
            in_rd     = 5'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 150) == 0;
            rstn      = ($urandom % 400) != 0;
            @(posedge clk); #1;
        end
        rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
